// File: rtl/dice_pkg.sv
// ============================================================================
// Module      : dice_pkg
// Description : Shared state encoding and default constants for the dice roller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dice_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROLLING = 2'd1,
    REPORT  = 2'd2
  } state_t;

  localparam int DEFAULT_FACES  = 6;
  localparam int DEFAULT_N_DICE = 2;

endpackage

`default_nettype wire

// File: rtl/dice_counter.sv
// ============================================================================
// Module      : dice_counter
// Description : One die: counts 1..FACES when enabled, 0 means "no throw yet".
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dice_counter
  import dice_pkg::*;
#(
  parameter  int FACES = DEFAULT_FACES,
  localparam int W     = $clog2(FACES + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] value,
  output logic         carry_out
);

  localparam logic [W-1:0] C_FACES = W'(FACES);
  localparam logic [W-1:0] C_ONE   = W'(1);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (en) begin
      value_d = ((value_q == '0) || (value_q == C_FACES)) ? C_ONE : value_q + C_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  // A step out of 0 is the first throw, not a wrap, so it never carries.
  assign carry_out = en & (value_q == C_FACES);
  assign value     = value_q;

endmodule

`default_nettype wire

// File: rtl/multi_dice_roller.sv
// ============================================================================
// Module      : multi_dice_roller
// Description : N-die odometer roller with hold mask, release report and roll counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_dice_roller
  import dice_pkg::*;
#(
  parameter  int N_DICE = DEFAULT_N_DICE,
  parameter  int FACES  = DEFAULT_FACES,
  parameter  int CW     = 8,
  localparam int W      = $clog2(FACES + 1),
  localparam int SW     = $clog2(N_DICE * FACES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  button,
  input  logic [N_DICE-1:0]     hold,
  output logic [N_DICE*W-1:0]   throws,
  output logic [SW-1:0]         sum,
  output logic                  all_equal,
  output logic                  done,
  output logic [CW-1:0]         roll_count
);

  logic [N_DICE-1:0] die_en;
  logic [N_DICE-1:0] die_carry;
  logic [N_DICE-1:0] carry_in;
  logic [W-1:0]      die_value [N_DICE];
  logic              unused_last_carry;

  // Held dice forward the incoming carry unchanged to the next die.
  always_comb begin
    carry_in    = '0;
    carry_in[0] = 1'b1;
    for (int i = 1; i < N_DICE; i++) begin
      carry_in[i] = hold[i-1] ? carry_in[i-1] : die_carry[i-1];
    end
    die_en = {N_DICE{button}} & ~hold & carry_in;
  end

  assign unused_last_carry = die_carry[N_DICE-1];

  for (genvar g = 0; g < N_DICE; g++) begin : g_die
    dice_counter #(
      .FACES (FACES)
    ) u_die (
      .clk       (clk),
      .rst       (rst),
      .en        (die_en[g]),
      .value     (die_value[g]),
      .carry_out (die_carry[g])
    );
    assign throws[g*W +: W] = die_value[g];
  end

  logic [SW-1:0] throw_sum;
  logic          throws_equal;

  always_comb begin
    throw_sum    = '0;
    throws_equal = (die_value[0] != '0);
    for (int i = 0; i < N_DICE; i++) begin
      throw_sum = throw_sum + SW'(die_value[i]);
      if (die_value[i] != die_value[0]) throws_equal = 1'b0;
    end
  end

  state_t        state_q;
  logic          done_q;
  logic [SW-1:0] sum_q;
  logic          all_equal_q;
  logic [CW-1:0] roll_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      done_q       <= 1'b0;
      sum_q        <= '0;
      all_equal_q  <= 1'b0;
      roll_count_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (button) state_q <= ROLLING;
        end
        ROLLING: begin
          if (!button) begin
            state_q     <= REPORT;
            done_q      <= 1'b1;
            sum_q       <= throw_sum;
            all_equal_q <= throws_equal;
            if (roll_count_q != {CW{1'b1}}) roll_count_q <= roll_count_q + CW'(1);
          end
        end
        REPORT: begin
          state_q <= button ? ROLLING : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sum        = sum_q;
  assign all_equal  = all_equal_q;
  assign done       = done_q;
  assign roll_count = roll_count_q;

endmodule

`default_nettype wire

// File: tb/tb_multi_dice_roller.sv
// ============================================================================
// Module      : tb_multi_dice_roller
// Description : Randomised scoreboard bench for multi_dice_roller (3 dice, d6, 3-bit counter).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_dice_roller;

  localparam int N  = 3;
  localparam int F  = 6;
  localparam int CW = 3;
  localparam int W  = $clog2(F + 1);
  localparam int SW = $clog2(N * F + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            button = 1'b0;
  logic [N-1:0]    hold = '0;
  logic [N*W-1:0]  throws;
  logic [SW-1:0]   sum;
  logic            all_equal;
  logic            done;
  logic [CW-1:0]   roll_count;

  multi_dice_roller #(.N_DICE(N), .FACES(F), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .button     (button),
    .hold       (hold),
    .throws     (throws),
    .sum        (sum),
    .all_equal  (all_equal),
    .done       (done),
    .roll_count (roll_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sum;
    int eq;
    int cnt;
  } report_t;

  report_t exp_q[$];

  int  n_checks = 0;
  int  n_errors = 0;
  bit  mon_en   = 1'b0;

  // Reference model: dice as plain integers, rolling = "button was high last edge".
  int  m_dice [N];
  bit  m_rolling;
  bit  m_done;
  int  m_sum, m_eq, m_cnt;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_dice[i] = 0;
    m_rolling = 0; m_done = 0; m_sum = 0; m_eq = 0; m_cnt = 0;
    exp_q.delete();
  endtask

  task automatic model_edge(input bit b, input bit [N-1:0] h);
    bit carry;
    int old, s, eq;
    m_done = 0;
    if (m_rolling && !b) begin
      s = 0; eq = (m_dice[0] != 0);
      for (int i = 0; i < N; i++) begin
        s += m_dice[i];
        if (m_dice[i] != m_dice[0]) eq = 0;
      end
      m_sum = s; m_eq = eq;
      m_cnt = (m_cnt == (1 << CW) - 1) ? m_cnt : m_cnt + 1;
      m_done = 1;
      exp_q.push_back('{sum: s, eq: eq, cnt: m_cnt});
    end
    if (b) begin
      carry = 1;
      for (int i = 0; i < N && carry; i++) begin
        if (!h[i]) begin
          old = m_dice[i];
          m_dice[i] = (old == 0 || old == F) ? 1 : old + 1;
          carry = (old == F);
        end
      end
    end
    m_rolling = b;
  endtask

  task automatic tick(input bit b, input bit [N-1:0] h, input bit r);
    @(negedge clk);
    button = b; hold = h; rst = r;
    @(posedge clk);
    if (r) model_reset();
    else   model_edge(b, h);
  endtask

  task automatic press(input int len, input bit [N-1:0] h);
    for (int i = 0; i < len; i++) tick(1'b1, h, 1'b0);
    tick(1'b0, h, 1'b0);
  endtask

  // Monitor: compares outputs against the model every cycle and pops the scoreboard on done.
  initial begin
    report_t r;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int i = 0; i < N; i++)
          chk($sformatf("die%0d", i), int'(throws[i*W +: W]), m_dice[i]);
        chk("done", int'(done), int'(m_done));
        chk("sum_held", int'(sum), m_sum);
        chk("all_equal_held", int'(all_equal), m_eq);
        chk("roll_count", int'(roll_count), m_cnt);
        if (done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            r = exp_q.pop_front();
            chk("report_sum", int'(sum), r.sum);
            chk("report_all_equal", int'(all_equal), r.eq);
            chk("report_count", int'(roll_count), r.cnt);
          end
        end
      end
    end
  end

  initial begin
    bit [N-1:0] h;
    model_reset();
    tick(1'b1, '0, 1'b1);
    tick(1'b1, '0, 1'b1);
    mon_en = 1'b1;

    press(7, 3'b000);          // odometer: die0 wraps into die1
    tick(1'b0, '0, 1'b0);
    press(10, 3'b010);         // held die passes carry to die 2
    press(8, 3'b000);

    tick(1'b1, '0, 1'b0);      // reset mid-roll: no done
    tick(1'b1, '0, 1'b0);
    tick(1'b1, '0, 1'b1);
    tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b0);
    press(5, 3'b111);          // all held: throws stay 0, count still advances

    for (int k = 0; k < 40; k++) begin
      h = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      for (int i = 0, len = $urandom_range(1, 25); i < len; i++) begin
        if ($urandom_range(0, 9) == 0) h = N'($urandom);
        tick(1'b1, h, ($urandom_range(0, 199) == 0));
      end
      for (int i = 0, len = $urandom_range(1, 3); i < len; i++) tick(1'b0, h, 1'b0);
    end
    press(3, 3'b000);
    tick(1'b1, '0, 1'b0);      // REPORT straight back to ROLLING
    tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b0);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
